// File: rtl/io_ports.sv
// io_ports: memory-mapped I/O window with synchronised inputs, output registers
// and a down-counting timer with a sticky flag and interrupt.
module io_ports #(
  parameter logic [11:0] BASE = 12'hFF0,
  parameter int          TW   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        irq
);
  logic [15:0]   r_out [4];
  logic [15:0]   r_s1  [4];
  logic [15:0]   r_s2  [4];
  logic [TW-1:0] r_reload, r_count;
  logic [2:0]    r_ctrl;
  logic          r_flag;
  logic [15:0]   w_in  [4];
  logic [15:0]   w_rd;
  logic [3:0]    w_off;
  logic          w_wr, w_ld, w_ctrl_wr, w_clr, w_set;
  assign w_in[0]   = in0;
  assign w_in[1]   = in1;
  assign w_in[2]   = in2;
  assign w_in[3]   = in3;
  assign hit       = addr[15:4] == BASE;
  assign w_off     = addr[3:0];
  assign w_wr      = we & hit;
  assign w_ld      = w_wr & (w_off == 4'h8);
  assign w_ctrl_wr = w_wr & (w_off == 4'hA);
  assign w_clr     = w_wr & (w_off == 4'hB) & wdata[0];
  // Expiry is seen on the edge where an enabled count is already 0; a RELOAD write suppresses it
  assign w_set     = r_ctrl[0] & ~w_ld & (r_count == '0);
  assign irq       = r_flag & r_ctrl[2];
  assign out0      = r_out[0];
  assign out1      = r_out[1];
  assign out2      = r_out[2];
  assign out3      = r_out[3];
  always_comb begin
    case (w_off)
      4'h0, 4'h1, 4'h2, 4'h3: w_rd = r_s2[w_off[1:0]];
      4'h4, 4'h5, 4'h6, 4'h7: w_rd = r_out[w_off[1:0]];
      4'h8:                   w_rd = 16'(r_reload);
      4'h9:                   w_rd = 16'(r_count);
      4'hA:                   w_rd = {13'h0, r_ctrl};
      4'hB:                   w_rd = {15'h0, r_flag};
      default:                w_rd = 16'h0000;
    endcase
    rdata = (re & hit) ? w_rd : 16'h0000;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_out[i] <= '0;
        r_s1[i]  <= '0;
        r_s2[i]  <= '0;
      end
      r_reload <= '0;
      r_count  <= '0;
      r_ctrl   <= '0;
      r_flag   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_s1[i] <= w_in[i];
        r_s2[i] <= r_s1[i];
        if (w_wr && w_off[3:2] == 2'b01 && w_off[1:0] == 2'(i)) r_out[i] <= wdata;
      end
      if (w_ld) begin
        r_reload <= wdata[TW-1:0];
        r_count  <= wdata[TW-1:0];
      end else if (r_ctrl[0]) begin
        r_count <= (r_count != '0) ? r_count - TW'(1) : (r_ctrl[1] ? r_reload : r_count);
      end
      r_flag <= w_set | (r_flag & ~w_clr);
      if (w_ctrl_wr) r_ctrl <= wdata[2:0];
      else if (w_set && !r_ctrl[1]) r_ctrl[0] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_ports.sv
// tb_io_ports: directed vectors; expected read data is queued at issue and
// checked by an independent monitor whenever a decoded read is presented.
module tb_io_ports;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0;
  logic [15:0] in0 = 16'h1111, in1 = 16'h2222, in2 = 16'h0000, in3 = 16'h4444;
  logic [15:0] out0, out1, out2, out3, rdata;
  logic        hit, irq;
  int          n_tests = 0, n_fail = 0;
  logic [15:0] qv[$];
  string       qn[$];

  io_ports dut (.clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .rdata(rdata), .hit(hit), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string n);
    @(posedge clk); #1;
    addr = a; we = 1'b0; re = 1'b1;
    qv.push_back(e); qn.push_back(n);
  endtask

  task automatic rw(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e, input string n);
    @(posedge clk); #1;
    addr = a; wdata = d; we = 1'b1; re = 1'b1;
    qv.push_back(e); qn.push_back(n);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  always @(negedge clk) begin
    if (re && hit) begin
      if (qv.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: addr %h rdata %h, expected no read", addr, rdata);
      end else begin
        chk(qn.pop_front(), rdata, qv.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    // build up state for the reset check: out1, flag=1, count=5, irq enabled
    wr(16'hFF05, 16'hBEEF);
    wr(16'hFF08, 16'h0000);
    wr(16'hFF0A, 16'h0001);
    idle();
    wr(16'hFF08, 16'h0005);
    wr(16'hFF0A, 16'h0004);
    rd(16'hFF09, 16'h0005, "pre_count");
    rd(16'hFF0B, 16'h0001, "pre_flag");
    chk("pre_irq", {15'h0, irq}, 16'h0001);
    rd(16'hFF05, 16'hBEEF, "pre_out1");
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; reset = 1'b0;
    #1;
    chk("rst_out1", out1, 16'h0000);
    chk("rst_irq", {15'h0, irq}, 16'h0000);
    rd(16'hFF09, 16'h0000, "rst_count");
    rd(16'hFF0B, 16'h0000, "rst_flag");
    idle();
    reset = 1'b1;
    rd(16'hFF05, 16'h0000, "post_out1");
    rd(16'hFF09, 16'h0000, "post_count");
    rd(16'hFF00, 16'h1111, "in0");
    rd(16'hFF03, 16'h4444, "in3");
    // decode
    wr(16'hFF05, 16'h1234);
    wr(16'hFE05, 16'h5555);
    chk("out1_wr", out1, 16'h1234);
    chk("hit_miss", {15'h0, hit}, 16'h0000);
    rd(16'hFF05, 16'h1234, "out1_rd");
    chk("out1_keep", out1, 16'h1234);
    @(posedge clk); #1;
    addr = 16'hFE05; re = 1'b1; we = 1'b0;
    #1 chk("miss_rdata", rdata, 16'h0000);
    wr(16'hFF0D, 16'hFFFF);
    rd(16'hFF0D, 16'h0000, "unmapped");
    // synchroniser: in2 changes just after edge N
    @(posedge clk); #1;
    in2 = 16'hA5A5; addr = 16'hFF02; we = 1'b0; re = 1'b1;
    qv.push_back(16'h0000); qn.push_back("sync_n");
    rd(16'hFF02, 16'h0000, "sync_n1");
    rd(16'hFF02, 16'hA5A5, "sync_n2");
    // one-shot timer
    wr(16'hFF08, 16'h0003);
    wr(16'hFF0A, 16'h0005);
    rd(16'hFF09, 16'h0003, "os_cnt3");
    rd(16'hFF09, 16'h0002, "os_cnt2");
    rd(16'hFF09, 16'h0001, "os_cnt1");
    rd(16'hFF09, 16'h0000, "os_cnt0");
    chk("os_irq_low", {15'h0, irq}, 16'h0000);
    rd(16'hFF0B, 16'h0001, "os_flag");
    chk("os_irq", {15'h0, irq}, 16'h0001);
    rd(16'hFF0A, 16'h0004, "os_ctrl");
    rd(16'hFF09, 16'h0000, "os_hold");
    // auto-reload and clear race
    wr(16'hFF0B, 16'h0001);
    wr(16'hFF08, 16'h0002);
    wr(16'hFF0A, 16'h0003);
    rd(16'hFF09, 16'h0002, "ar_cnt2");
    rd(16'hFF09, 16'h0001, "ar_cnt1");
    rd(16'hFF09, 16'h0000, "ar_cnt0");
    rw(16'hFF0B, 16'h0001, 16'h0001, "ar_flag1");
    rd(16'hFF0B, 16'h0000, "ar_clr");
    wr(16'hFF0B, 16'h0001);
    rd(16'hFF0B, 16'h0001, "ar_race");
    chk("ar_irq_off", {15'h0, irq}, 16'h0000);
    rd(16'hFF09, 16'h0001, "ar_reload");
    wr(16'hFF0A, 16'h0000);
    wr(16'hFF0B, 16'h0001);
    rd(16'hFF0B, 16'h0000, "ar_final");
    rd(16'hFF08, 16'h0002, "reload_rd");
    wr(16'hFF0A, 16'hFFF8);
    rd(16'hFF0A, 16'h0000, "ctrl_mask");
    // same-cycle read/write
    wr(16'hFF04, 16'h00FF);
    rw(16'hFF04, 16'h0F0F, 16'h00FF, "rw_old");
    rd(16'hFF04, 16'h0F0F, "rw_new");
    idle();
    chk("out0", out0, 16'h0F0F);
    repeat (3) idle();
    chk("sb_drain", 16'(qv.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
